// File: rtl/ext_access_gatekeeper_if.sv
// External request/response channel of the access gatekeeper.
// master: untrusted requester side; slave: gatekeeper side.
interface ext_access_gatekeeper_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ext_access_gatekeeper.sv
// Buffers external requests, blocks accesses to a protected window and
// to the all-ones alias, forwards the rest to memory as single-cycle strobes.
// Ports: clk, reset_n; ext (request/response channel, slave side);
// cfg_we/cfg_lo/cfg_hi/cfg_lock/cfg_locked (privileged window control);
// mem_cs/mem_wr/mem_addr/mem_wdata/mem_rdata (memory port);
// viol_count (saturating rejection counter).
module ext_access_gatekeeper #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ext_access_gatekeeper_if.slave ext,
    input  logic                  cfg_we,
    input  logic [ADDR_WIDTH-1:0] cfg_lo,
    input  logic [ADDR_WIDTH-1:0] cfg_hi,
    input  logic                  cfg_lock,
    output logic                  cfg_locked,
    output logic                  mem_cs,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [7:0]            viol_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONES = '1;
    localparam logic [ADDR_WIDTH-1:0] LO_RST = ONES - ADDR_WIDTH'(15);

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, RESP} state_t;

    req_t   fifo_q [FIFO_DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;

    state_t state;
    req_t   hold;
    logic [ADDR_WIDTH-1:0] prot_lo;
    logic [ADDR_WIDTH-1:0] prot_hi;
    logic   reject;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign ext.req_ready = !full;
    assign push = ext.req_valid && !full;
    assign pop  = (state == IDLE) && !empty;

    // All-ones is aliased downstream to the privileged address.
    assign reject = ((hold.addr >= prot_lo) && (hold.addr <= prot_hi)) ||
                    (hold.addr == ONES);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr[PW-1:0]] <= '{wr:    ext.req_wr,
                                       addr:  ext.req_addr,
                                       wdata: ext.req_wdata};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Write-then-lock ordering: a same-cycle write still lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prot_lo    <= LO_RST;
            prot_hi    <= ONES;
            cfg_locked <= 1'b0;
        end else begin
            if (cfg_we && !cfg_locked) begin
                prot_lo <= cfg_lo;
                prot_hi <= cfg_hi;
            end
            if (cfg_lock) cfg_locked <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            hold          <= '0;
            mem_cs        <= 1'b0;
            mem_wr        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            ext.rsp_valid <= 1'b0;
            ext.rsp_rdata <= '0;
            ext.rsp_err   <= 1'b0;
            viol_count    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        hold  <= fifo_q[rd_ptr[PW-1:0]];
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (reject) begin
                        if (viol_count != 8'hFF)
                            viol_count <= viol_count + 8'd1;
                        ext.rsp_err   <= 1'b1;
                        ext.rsp_rdata <= '0;
                        ext.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        mem_cs    <= 1'b1;
                        mem_wr    <= hold.wr;
                        mem_addr  <= hold.addr;
                        mem_wdata <= hold.wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_cs        <= 1'b0;
                    mem_wr        <= 1'b0;
                    ext.rsp_rdata <= hold.wr ? '0 : mem_rdata;
                    ext.rsp_err   <= 1'b0;
                    ext.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (ext.rsp_ready) begin
                        ext.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ext_access_gatekeeper.sv
// Directed testbench for ext_access_gatekeeper.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ext_access_gatekeeper;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_we;
    logic [7:0]  cfg_lo;
    logic [7:0]  cfg_hi;
    logic        cfg_lock;
    logic        cfg_locked;
    logic        mem_cs;
    logic        mem_wr;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [7:0]  viol_count;

    int passed = 0;
    int total  = 0;
    int cs_cnt = 0;
    int cs_double = 0;
    logic cs_prev = 1'b0;
    logic last_wr = 1'b0;
    logic [31:0] last_wdata = '0;

    ext_access_gatekeeper_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) ext ();

    ext_access_gatekeeper #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ext(ext),
        .cfg_we(cfg_we), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
        .cfg_lock(cfg_lock), .cfg_locked(cfg_locked),
        .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .viol_count(viol_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mval(input logic [7:0] a);
        return {24'hC0FFEE, a};
    endfunction

    assign mem_rdata = {24'hC0FFEE, mem_addr};

    always @(posedge clk) begin
        if (mem_cs) begin
            cs_cnt++;
            last_wr = mem_wr;
            last_wdata = mem_wdata;
            if (cs_prev) cs_double++;
        end
        cs_prev = mem_cs;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_req(input logic wr, input logic [7:0] a,
                          input logic [31:0] wd,
                          output logic [31:0] rd, output logic err);
        int n = 0;
        ext.req_valid = 1'b1;
        ext.req_wr    = wr;
        ext.req_addr  = a;
        ext.req_wdata = wd;
        ext.rsp_ready = 1'b1;
        while (!ext.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        ext.req_valid = 1'b0;
        n = 0;
        while (!ext.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rsp_timeout", n, 0);
        rd  = ext.rsp_rdata;
        err = ext.rsp_err;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int base;
        int n;

        reset_n = 1'b0;
        cfg_we = 1'b0; cfg_lo = '0; cfg_hi = '0; cfg_lock = 1'b0;
        ext.req_valid = 1'b0; ext.req_wr = 1'b0;
        ext.req_addr = '0; ext.req_wdata = '0; ext.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", ext.rsp_valid, 0);
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_viol", viol_count, 0);
        chk("rst_locked", cfg_locked, 0);
        chk("rst_req_ready", ext.req_ready, 1);
        reset_n = 1'b1;
        @(negedge clk);

        // Latency: push cycle 0, strobe cycle 3, response cycle 4.
        ext.req_valid = 1'b1; ext.req_wr = 1'b0; ext.req_addr = 8'h10;
        @(negedge clk);
        ext.req_valid = 1'b0;
        chk("lat_c1_cs", mem_cs, 0);
        @(negedge clk);
        chk("lat_c2_cs", mem_cs, 0);
        @(negedge clk);
        chk("lat_c3_cs", mem_cs, 1);
        chk("lat_c3_addr", mem_addr, 8'h10);
        chk("lat_c3_wr", mem_wr, 0);
        chk("lat_c3_rv", ext.rsp_valid, 0);
        @(negedge clk);
        chk("lat_c4_rv", ext.rsp_valid, 1);
        chk("lat_c4_rdata", ext.rsp_rdata, mval(8'h10));
        chk("lat_c4_err", ext.rsp_err, 0);
        chk("lat_c4_cs", mem_cs, 0);
        @(negedge clk);
        chk("lat_c5_rv", ext.rsp_valid, 0);
        chk("lat_cs_cnt", cs_cnt, 1);

        // Default window 0xF0..0xFF.
        base = cs_cnt;
        do_req(1'b1, 8'hF5, 32'hDEADBEEF, rd, err);
        chk("wF5_err", err, 1);
        chk("wF5_rdata", rd, 0);
        do_req(1'b1, 8'hFF, 32'h11111111, rd, err);
        chk("wFF_err", err, 1);
        chk("wFF_rdata", rd, 0);
        chk("blocked_no_cs", cs_cnt - base, 0);
        chk("viol_2", viol_count, 2);
        do_req(1'b0, 8'hEF, 32'h0, rd, err);
        chk("rEF_err", err, 0);
        chk("rEF_rdata", rd, mval(8'hEF));
        do_req(1'b0, 8'hF0, 32'h0, rd, err);
        chk("rF0_err", err, 1);
        chk("viol_3", viol_count, 3);

        // Window programming and lock.
        cfg_we = 1'b1; cfg_lo = 8'h20; cfg_hi = 8'h2F;
        @(negedge clk);
        cfg_we = 1'b0; cfg_lock = 1'b1;
        @(negedge clk);
        cfg_lock = 1'b0; cfg_we = 1'b1; cfg_lo = 8'h00; cfg_hi = 8'h00;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("locked", cfg_locked, 1);
        do_req(1'b0, 8'h25, 32'h0, rd, err);
        chk("r25_err", err, 1);
        base = cs_cnt;
        do_req(1'b1, 8'hF5, 32'h12345678, rd, err);
        chk("wF5b_err", err, 0);
        chk("wF5b_rdata", rd, 0);
        chk("wF5b_cs", cs_cnt - base, 1);
        chk("wF5b_wr", last_wr, 1);
        chk("wF5b_wdata", last_wdata, 32'h12345678);
        do_req(1'b0, 8'h00, 32'h0, rd, err);
        chk("r00_err", err, 0);
        chk("r00_rdata", rd, mval(8'h00));
        do_req(1'b0, 8'h2F, 32'h0, rd, err);
        chk("r2F_err", err, 1);
        chk("viol_5", viol_count, 5);

        // Backpressure: five reads, responses stalled.
        base = cs_cnt;
        ext.rsp_ready = 1'b0;
        ext.req_wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ext.req_valid = 1'b1;
            ext.req_addr  = 8'h30 + 8'(i);
            chk("push_ready", ext.req_ready, 1);
            @(negedge clk);
        end
        ext.req_valid = 1'b0;
        chk("full_ready", ext.req_ready, 0);
        repeat (4) @(negedge clk);
        chk("stall_rv", ext.rsp_valid, 1);
        chk("stall_rdata", ext.rsp_rdata, mval(8'h30));
        chk("stall_ready", ext.req_ready, 0);
        chk("stall_cs", cs_cnt - base, 1);
        ext.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!ext.rsp_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("order_rdata", ext.rsp_rdata, mval(8'h30 + 8'(i)));
            @(negedge clk);
        end
        chk("burst_cs", cs_cnt - base, 5);
        chk("cs_single", cs_double, 0);
        chk("drain_ready", ext.req_ready, 1);

        // Saturation.
        for (int i = 0; i < 256; i++) begin
            do_req(1'b0, 8'hFF, 32'h0, rd, err);
            if (i == 249) chk("viol_255", viol_count, 8'hFF);
        end
        chk("sat_err", err, 1);
        chk("viol_sat", viol_count, 8'hFF);

        // Reset with a request in RESP and three queued.
        base = cs_cnt;
        ext.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ext.req_valid = 1'b1;
            ext.req_addr  = 8'h40 + 8'(i);
            @(negedge clk);
        end
        chk("pre_rst_rv", ext.rsp_valid, 1);
        chk("pre_rst_cs", cs_cnt - base, 1);
        reset_n = 1'b0;
        ext.req_valid = 1'b0;
        #1;
        chk("arst_rv", ext.rsp_valid, 0);
        chk("arst_cs", mem_cs, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_wdata", mem_wdata, 0);
        chk("arst_rdata", ext.rsp_rdata, 0);
        chk("arst_err", ext.rsp_err, 0);
        chk("arst_viol", viol_count, 0);
        chk("arst_locked", cfg_locked, 0);
        chk("arst_ready", ext.req_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_cs", cs_cnt - base, 1);
        chk("post_rst_rv", ext.rsp_valid, 0);
        chk("post_rst_ready", ext.req_ready, 1);
        do_req(1'b0, 8'hF0, 32'h0, rd, err);
        chk("post_rst_win", err, 1);
        chk("post_rst_viol", viol_count, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
